// File: rtl/hazard_controller.sv
// hazard_controller: sequencing controller for a 5-stage RISC-V pipeline.
// It keeps shadow copies of the E/M/W destination and control fields. From
// those it drives stall, flush and forwarding selects for load-use hazards,
// taken branches and multi-cycle data-memory waits. It also keeps a
// saturating count of stalled cycles.
// Optional feature: define HAZARD_MEM_TIMEOUT_EN to bound a memory wait to
// TIMEOUT cycles. When the bound is reached, the M entry is dropped and the
// sticky mem_err flag is set.
module hazard_controller #(
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    input  logic [REG_W-1:0] de_rs1,
    input  logic [REG_W-1:0] de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic [REG_W-1:0] de_rd,
    input  logic             de_we,
    input  logic             de_mem_reg,
    input  logic             de_mem_we,
    input  logic             ex_brn_taken,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

    state_t state_q, state_d;

    // Shadow pipeline entries; an all-zero entry is a bubble.
    logic [1:0][REG_W-1:0] e_rs_q, e_rs_d;
    logic [REG_W-1:0]      e_rd_q, e_rd_d;
    logic                  e_we_q, e_we_d, e_ld_q, e_ld_d, e_mem_q, e_mem_d;
    logic [REG_W-1:0]      m_rd_q, m_rd_d;
    logic                  m_we_q, m_we_d, m_ld_q, m_ld_d, m_mem_q, m_mem_d;
    logic [REG_W-1:0]      w_rd_q, w_rd_d;
    logic                  w_we_q, w_we_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic [1:0][REG_W-1:0] de_rs;
    logic [1:0]            de_use;
    logic [1:0]            src_match;
    logic [1:0][1:0]       fwd_sel;
    logic                  mem_stall;
    logic                  load_use;
    logic                  lu_stall;
    logic                  br_flush;
    logic                  any_stall;
    logic                  timeout_hit;

    assign de_rs  = {de_rs2, de_rs1};
    assign de_use = {de_use_rs2, de_use_rs1};

    // Per-operand hazard match and forward select. A write to x0 never
    // matches. A load sitting in M cannot forward; its data only exists
    // once the load reaches W.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = de_use[gi] && (de_rs[gi] == e_rd_q);
            assign fwd_sel[gi] =
                (m_we_q && !m_ld_q && (m_rd_q != '0) && (m_rd_q == e_rs_q[gi])) ? 2'b10 :
                (w_we_q && (w_rd_q != '0) && (w_rd_q == e_rs_q[gi]))            ? 2'b01 :
                                                                                   2'b00;
        end
    endgenerate

    assign mem_stall = (m_ld_q || m_mem_q) && !mem_ready;
    assign load_use  = e_ld_q && (e_rd_q != '0) && de_valid && (|src_match);
    assign br_flush  = !mem_stall && ex_brn_taken;
    assign lu_stall  = !mem_stall && !ex_brn_taken && load_use;
    assign any_stall = mem_stall || lu_stall;

`ifdef HAZARD_MEM_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    assign timeout_hit = (state_q == MEM_WAIT) && mem_stall &&
                         (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    // The wait counter only runs while in MEM_WAIT. The error flag stays set
    // until the next reset.
    always_comb begin
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q || timeout_hit;
        if (state_q == MEM_WAIT && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Timeout bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = !rst && mem_err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // Next-state logic for the FSM, the shadow entries and the stall counter.
    always_comb begin
        state_d     = state_q;
        e_rs_d      = e_rs_q;
        e_rd_d      = e_rd_q;
        e_we_d      = e_we_q;
        e_ld_d      = e_ld_q;
        e_mem_d     = e_mem_q;
        m_rd_d      = m_rd_q;
        m_we_d      = m_we_q;
        m_ld_d      = m_ld_q;
        m_mem_d     = m_mem_q;
        w_rd_d      = w_rd_q;
        w_we_d      = w_we_q;
        stall_cnt_d = stall_cnt_q;

        if (mem_stall) begin
            // Whole pipeline frozen while memory is busy.
            state_d = MEM_WAIT;
            if (timeout_hit) begin
                state_d = RUN;
                m_rd_d  = '0;
                m_we_d  = 1'b0;
                m_ld_d  = 1'b0;
                m_mem_d = 1'b0;
            end
        end else begin
            state_d = RUN;
            m_rd_d  = e_rd_q;
            m_we_d  = e_we_q;
            m_ld_d  = e_ld_q;
            m_mem_d = e_mem_q;
            w_rd_d  = m_rd_q;
            w_we_d  = m_we_q;
            if (ex_brn_taken || load_use || !de_valid) begin
                e_rs_d  = '0;
                e_rd_d  = '0;
                e_we_d  = 1'b0;
                e_ld_d  = 1'b0;
                e_mem_d = 1'b0;
            end else begin
                e_rs_d  = de_rs;
                e_rd_d  = de_rd;
                e_we_d  = de_we;
                e_ld_d  = de_mem_reg;
                e_mem_d = de_mem_we;
            end
        end

        if (any_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, shadow-entry and counter registers; reset leaves all bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            e_rs_q      <= '0;
            e_rd_q      <= '0;
            e_we_q      <= 1'b0;
            e_ld_q      <= 1'b0;
            e_mem_q     <= 1'b0;
            m_rd_q      <= '0;
            m_we_q      <= 1'b0;
            m_ld_q      <= 1'b0;
            m_mem_q     <= 1'b0;
            w_rd_q      <= '0;
            w_we_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            e_rs_q      <= e_rs_d;
            e_rd_q      <= e_rd_d;
            e_we_q      <= e_we_d;
            e_ld_q      <= e_ld_d;
            e_mem_q     <= e_mem_d;
            m_rd_q      <= m_rd_d;
            m_we_q      <= m_we_d;
            m_ld_q      <= m_ld_d;
            m_mem_q     <= m_mem_d;
            w_rd_q      <= w_rd_d;
            w_we_q      <= w_we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted. This matters for the
    // paths that come straight from inputs, such as the branch flush.
    assign stall_f   = !rst && any_stall;
    assign stall_d   = !rst && any_stall;
    assign stall_e   = !rst && mem_stall;
    assign stall_m   = !rst && mem_stall;
    assign flush_d   = !rst && br_flush;
    assign flush_e   = !rst && (br_flush || lu_stall);
    assign fwd_a     = rst ? 2'b00 : fwd_sel[0];
    assign fwd_b     = rst ? 2'b00 : fwd_sel[1];
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller with hand-computed expectations.
// It covers load-use stalls, M/W forwarding, the x0 rule, and a branch that
// overrides a load-use hazard. It also covers memory waits, reset during a
// wait and (with HAZARD_MEM_TIMEOUT_EN) the wait timeout.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       de_valid;
    logic [4:0] de_rs1, de_rs2, de_rd;
    logic       de_use_rs1, de_use_rs2, de_we, de_mem_reg, de_mem_we;
    logic       ex_brn_taken, mem_ready;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic       mem_err;

    int total = 0;
    int bad   = 0;

    hazard_controller #(.REG_W(5), .CNT_W(16), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .de_valid     (de_valid),
        .de_rs1       (de_rs1),
        .de_rs2       (de_rs2),
        .de_use_rs1   (de_use_rs1),
        .de_use_rs2   (de_use_rs2),
        .de_rd        (de_rd),
        .de_we        (de_we),
        .de_mem_reg   (de_mem_reg),
        .de_mem_we    (de_mem_we),
        .ex_brn_taken (ex_brn_taken),
        .mem_ready    (mem_ready),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cnt    (stall_cnt),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic st);
        de_valid   = v;
        de_rs1     = r1;
        de_rs2     = r2;
        de_use_rs1 = u1;
        de_use_rs2 = u2;
        de_rd      = rd;
        de_we      = we;
        de_mem_reg = ld;
        de_mem_we  = st;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Stall/flush outputs packed as {f,d,e,m,fd,fe}.
    function automatic logic [5:0] ctl();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ex_brn_taken = 1'b0;
        mem_ready = 1'b1;
        idle();
        mid();
        chk("rst_ctl", 32'(ctl()), 32'd0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        cyc();
        rst = 1'b0;

        // lw x5,0(x1)
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        mid(); chk("lw_ctl", 32'(ctl()), 32'd0);
        cyc();
        // add x6,x5,x1 right behind the load: load-use stall
        drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        mid(); chk("lu_ctl", 32'(ctl()), 32'b110001);
        chk("lu_fwda", 32'(fwd_a), 32'd0);
        cyc();
        mid(); chk("lu_after_ctl", 32'(ctl()), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        cyc();
        // add x3,x1,x2 in D; add x6 now in E with lw in W
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        mid(); chk("lu_fwda_w", 32'(fwd_a), 32'b01);
        chk("lu_fwdb", 32'(fwd_b), 32'b00);
        cyc();
        // sub x4,x3,x3
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        mid(); chk("alu_ctl", 32'(ctl()), 32'd0);
        chk("alu_fwd_none", 32'({fwd_a, fwd_b}), 32'd0);
        cyc();
        // add x0,x1,x2
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        mid(); chk("sub_fwd_mm", 32'({fwd_a, fwd_b}), 32'b1010);
        cyc();
        // sub x4,x0,x0
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        cyc();
        // addi x7,x1 ; sub x4,x0,x0 is in E with add x0 in M
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        mid(); chk("x0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        cyc();
        // addi x7,x2
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        cyc();
        // add x8,x7,x9
        drive(1'b1, 5'd7, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        cyc();
        idle();
        mid(); chk("m_beats_w", 32'(fwd_a), 32'b10);
        chk("m_beats_w_b", 32'(fwd_b), 32'b00);
        cyc();
        // add x11,x1,x8 after a bubble: x8 comes from W
        drive(1'b1, 5'd1, 5'd8, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        cyc();
        // lw x5 in D while add x11 is in E
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        mid(); chk("w_fwd", 32'({fwd_a, fwd_b}), 32'b0001);
        cyc();
        // Taken branch together with a load-use match
        drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        ex_brn_taken = 1'b1;
        mid(); chk("br_ctl", 32'(ctl()), 32'b000011);
        cyc();
        ex_brn_taken = 1'b0;
        idle();
        mid(); chk("br_cnt", 32'(stall_cnt), 32'd1);
        chk("br_after_ctl", 32'(ctl()), 32'd0);
        cyc();

        // Store that waits three cycles in M
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        idle();
        cyc();
        mem_ready = 1'b0;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mid(); chk($sformatf("mw_ctl%0d", i), 32'(ctl()), 32'b111100);
            cyc();
        end
        mem_ready = 1'b1;
        mid(); chk("mw_done_ctl", 32'(ctl()), 32'd0);
        chk("mw_cnt", 32'(stall_cnt), 32'd4);
        cyc();
        idle();
        mid(); chk("mw_adv_cnt", 32'(stall_cnt), 32'd4);
        cyc();

        // Reset while waiting on memory
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        idle();
        cyc();
        mem_ready = 1'b0;
        mid(); chk("rw_stall", 32'(stall_m), 32'd1);
        cyc();
        mid(); chk("rw_cnt", 32'(stall_cnt), 32'd5);
        #1;
        rst = 1'b1;
        ex_brn_taken = 1'b1;
        #1;
        chk("rw_async_ctl", 32'(ctl()), 32'd0);
        chk("rw_async_cnt", 32'(stall_cnt), 32'd0);
        cyc();
        rst = 1'b0;
        ex_brn_taken = 1'b0;
        mid(); chk("rw_run_ctl", 32'(ctl()), 32'd0);
        chk("rw_run_cnt", 32'(stall_cnt), 32'd0);
        chk("rw_err", 32'(mem_err), 32'd0);
        cyc();

`ifdef HAZARD_MEM_TIMEOUT_EN
        // mem_ready stuck low: one RUN cycle plus four wait cycles, then timeout
        mem_ready = 1'b1;
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        idle();
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid(); chk($sformatf("to_stall%0d", i), 32'(stall_m), 32'd1);
            cyc();
        end
        mid(); chk("to_err", 32'(mem_err), 32'd1);
        chk("to_resume", 32'(ctl()), 32'd0);
        cyc();
        cyc();
        mid(); chk("to_sticky", 32'(mem_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("to_rst_err", 32'(mem_err), 32'd0);
        cyc();
        rst = 1'b0;
        mem_ready = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
